// File: rtl/axi_hp0_rd.sv
// AXI3 read master for the Zynq HP0 port: walks a circular DDR region in fixed INCR
// bursts and unpacks each 64-bit beat into four 16-bit words on a valid/ready stream.
module axi_hp0_rd #(
  parameter logic [31:0] STAR_ADDR   = 32'h0040_0000,
  parameter int          BURST_LEN   = 16,
  parameter logic [31:0] FRAME_BYTES = 32'h0010_0000
) (
  input  logic        AXI_clk,
  input  logic        rst_n,
  input  logic        i_rd_en,
  input  logic        i_addr_rst,
  output logic [15:0] o_data,
  output logic        o_data_en,
  input  logic        i_data_rdy,
  output logic        o_frame_done,
  output logic        o_rd_err,
  output logic [31:0] AXI_araddr,
  output logic [3:0]  AXI_arlen,
  output logic [2:0]  AXI_arsize,
  output logic [1:0]  AXI_arburst,
  output logic [1:0]  AXI_arlock,
  output logic [3:0]  AXI_arcache,
  output logic [2:0]  AXI_arprot,
  output logic [3:0]  AXI_arqos,
  output logic        AXI_arvalid,
  input  logic        AXI_arready,
  input  logic [63:0] AXI_rdata,
  input  logic [5:0]  AXI_rid,
  input  logic [1:0]  AXI_rresp,
  input  logic        AXI_rlast,
  input  logic        AXI_rvalid,
  output logic        AXI_rready
);

  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);
  localparam logic [31:0] END_ADDR    = STAR_ADDR + FRAME_BYTES;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state;
  logic [31:0] addr;
  logic        arvalid_q;
  logic [63:0] beat_buf;
  logic [1:0]  word_idx;
  logic        buf_full;
  logic        rst_pend;
  logic        frame_done_q;
  logic        rd_err_q;
  logic [31:0] next_addr;
  logic        beat_ok;
  logic        word_acc;
  logic        unused_rid;

  assign AXI_arlen   = 4'(BURST_LEN - 1);
  assign AXI_arsize  = 3'b011;
  assign AXI_arburst = 2'b01;
  assign AXI_arlock  = 2'b00;
  assign AXI_arcache = 4'b0011;
  assign AXI_arprot  = 3'b000;
  assign AXI_arqos   = 4'b0000;
  assign unused_rid  = ^AXI_rid;

  assign AXI_araddr   = addr;
  assign AXI_arvalid  = arvalid_q;
  // Handshakes: a transfer occurs on the rising edge where valid & ready are both high.
  // rready is derived only from registers, so a freed buffer is re-offered one cycle later.
  assign AXI_rready   = (state == DATA) && !buf_full;
  assign o_data_en    = buf_full;
  assign o_frame_done = frame_done_q;
  assign o_rd_err     = rd_err_q;

  assign beat_ok   = AXI_rvalid && AXI_rready;
  assign word_acc  = buf_full && i_data_rdy;
  assign next_addr = addr + BURST_BYTES;

  always_comb begin
    o_data = beat_buf[15:0];
    case (word_idx)
      2'd1:    o_data = beat_buf[31:16];
      2'd2:    o_data = beat_buf[47:32];
      2'd3:    o_data = beat_buf[63:48];
      default: o_data = beat_buf[15:0];
    endcase
  end

  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= STAR_ADDR;
      arvalid_q    <= 1'b0;
      beat_buf     <= '0;
      word_idx     <= 2'd0;
      buf_full     <= 1'b0;
      rst_pend     <= 1'b0;
      frame_done_q <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (i_addr_rst) rst_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (rst_pend || i_addr_rst) begin
            addr     <= STAR_ADDR;
            rst_pend <= 1'b0;
          end
          if (i_rd_en) begin
            state     <= ADDR;
            arvalid_q <= 1'b1;
          end
        end
        ADDR: begin
          if (AXI_arready) begin
            arvalid_q <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          // rlast alone ends the burst, whatever the beat count.
          if (beat_ok && AXI_rlast) begin
            state <= IDLE;
            if (rst_pend || i_addr_rst) begin
              addr     <= STAR_ADDR;
              rst_pend <= 1'b0;
            end else if (next_addr == END_ADDR) begin
              addr         <= STAR_ADDR;
              frame_done_q <= 1'b1;
            end else begin
              addr <= next_addr;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (beat_ok) begin
        beat_buf <= AXI_rdata;
        word_idx <= 2'd0;
        buf_full <= 1'b1;
        if (AXI_rresp != 2'b00) rd_err_q <= 1'b1;
      end else if (word_acc) begin
        word_idx <= word_idx + 2'd1;
        if (word_idx == 2'd3) buf_full <= 1'b0;
      end
    end
  end

endmodule
